// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode, funct and ALU op constants for the MIPS control unit
// Purpose: one definition of the encodings used by mc_control, alu_decode and the ALU.
// Ports: none (package).
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC,
      S_ALUWB,
      S_BRANCH,
      S_ADDIEX,
      S_ADDIWB,
      S_JUMP,
      S_ILLEGAL
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control unit to datapath signal bundle
// Purpose: groups IR fields, ALU flags, memory handshake and all control outputs.
// Ports: none; master modport is the control unit, slave modport is the datapath side.
interface mc_control_if;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       overflow;
   logic       mem_ready;

   logic [3:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic       pc_write;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       illegal_op;
   logic       ovf_err;

   modport master (
      input  opcode, funct, zero, overflow, mem_ready,
      output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, iord, mem_read,
             mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, ovf_err
   );

   modport slave (
      output opcode, funct, zero, overflow, mem_ready,
      input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, iord, mem_read,
             mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, ovf_err
   );

endinterface

// File: rtl/mc_control_alu_decode.sv
// rtl/mc_control_alu_decode.sv - R-type funct to ALU operation decoder
// Purpose: combinational funct decode shared by DECODE (legality) and EXEC (operation).
// Ports: funct in 6; alu_op out 4; legal out 1 (supported funct); is_addsub out 1 (ADD or SUB).
module alu_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       legal,
   output logic       is_addsub
);

   always_comb begin
      alu_op    = ALU_AND;
      legal     = 1'b1;
      is_addsub = 1'b0;
      case (funct)
         FN_ADD: begin alu_op = ALU_ADD; is_addsub = 1'b1; end
         FN_SUB: begin alu_op = ALU_SUB; is_addsub = 1'b1; end
         FN_AND: alu_op = ALU_AND;
         FN_OR:  alu_op = ALU_OR;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control FSM driving the ALU op and datapath enables
// Purpose: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and decodes Moore outputs from state.
// Ports: clk in 1; reset_n in 1 (async, active low); bus master modport of mc_control_if
//        (opcode/funct/zero/overflow/mem_ready in; alu_op, selects, enables, illegal_op, ovf_err out).
module mc_control
   import mips_ctrl_pkg::*;
#(
   parameter int SIZE = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   mc_control_if.master  bus
);

   if (SIZE < 1) begin : g_size_check
      $error("mc_control: SIZE must be positive");
   end

   state_t     state, state_nxt;
   logic       ovf_q, ovf_nxt;
   // LW/SW choice is captured in DECODE so opcode may change after it.
   logic       is_sw_q, is_sw_nxt;
   logic [3:0] dec_op;
   logic       dec_legal;
   logic       dec_addsub;

   alu_decode u_alu_decode (
      .funct     (bus.funct),
      .alu_op    (dec_op),
      .legal     (dec_legal),
      .is_addsub (dec_addsub)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_FETCH;
         ovf_q   <= 1'b0;
         is_sw_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         ovf_q   <= ovf_nxt;
         is_sw_q <= is_sw_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      ovf_nxt        = ovf_q;
      is_sw_nxt      = is_sw_q;
      bus.alu_op     = ALU_AND;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = SRCB_REG;
      bus.pc_src     = PC_ALU;
      bus.pc_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.illegal_op = 1'b0;
      bus.ovf_err    = 1'b0;

      case (state)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = SRCB_FOUR;
            bus.alu_op    = ALU_ADD;
            // IR and PC+4 only commit on the cycle the fetch completes.
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
            if (bus.mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            bus.alu_src_b = SRCB_IMM4;
            bus.alu_op    = ALU_ADD;
            is_sw_nxt     = (bus.opcode == OP_SW);
            case (bus.opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = dec_legal ? S_EXEC : S_ILLEGAL;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_J:         state_nxt = S_JUMP;
               default:      state_nxt = S_ILLEGAL;
            endcase
         end
         S_MEMADR, S_ADDIEX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_op    = ALU_ADD;
            if (state == S_ADDIEX) state_nxt = S_ADDIWB;
            else                   state_nxt = is_sw_q ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
            if (bus.mem_ready) state_nxt = S_MEMWB;
         end
         S_MEMWR: begin
            bus.mem_write = 1'b1;
            bus.iord      = 1'b1;
            if (bus.mem_ready) state_nxt = S_FETCH;
         end
         S_MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = dec_op;
            // Only ADD/SUB can overflow; logic ops always write back.
            ovf_nxt       = dec_addsub & bus.overflow;
            state_nxt     = S_ALUWB;
         end
         S_ALUWB: begin
            bus.reg_dst   = 1'b1;
            bus.reg_write = ~ovf_q;
            bus.ovf_err   = ovf_q;
            state_nxt     = S_FETCH;
         end
         S_ADDIWB: begin
            bus.reg_write = 1'b1;
            state_nxt     = S_FETCH;
         end
         S_BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = ALU_SUB;
            bus.pc_src    = PC_ALUOUT;
            bus.pc_write  = bus.zero;
            state_nxt     = S_FETCH;
         end
         S_JUMP: begin
            bus.pc_src   = PC_JUMP;
            bus.pc_write = 1'b1;
            state_nxt    = S_FETCH;
         end
         S_ILLEGAL: begin
            bus.illegal_op = 1'b1;
            state_nxt      = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - scoreboard testbench for mc_control
module tb_mc_control;

   typedef struct {
      string       name;
      logic [18:0] v;
   } exp_t;

   // {alu_op, src_a, src_b, pc_src, pc_write, iord, mem_read, mem_write,
   //  ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, ovf_err}
   localparam logic [18:0] E_FETCH    = {4'b0010, 1'b0, 2'b01, 2'b00, 10'b1010100000};
   localparam logic [18:0] E_FSTALL   = {4'b0010, 1'b0, 2'b01, 2'b00, 10'b0010000000};
   localparam logic [18:0] E_DECODE   = {4'b0010, 1'b0, 2'b11, 2'b00, 10'b0000000000};
   localparam logic [18:0] E_MEMADR   = {4'b0010, 1'b1, 2'b10, 2'b00, 10'b0000000000};
   localparam logic [18:0] E_MEMRD    = {4'b0000, 1'b0, 2'b00, 2'b00, 10'b0110000000};
   localparam logic [18:0] E_MEMWR    = {4'b0000, 1'b0, 2'b00, 2'b00, 10'b0101000000};
   localparam logic [18:0] E_MEMWB    = {4'b0000, 1'b0, 2'b00, 2'b00, 10'b0000001100};
   localparam logic [18:0] E_EXSUB    = {4'b0110, 1'b1, 2'b00, 2'b00, 10'b0000000000};
   localparam logic [18:0] E_EXAND    = {4'b0000, 1'b1, 2'b00, 2'b00, 10'b0000000000};
   localparam logic [18:0] E_ALUWB    = {4'b0000, 1'b0, 2'b00, 2'b00, 10'b0000010100};
   localparam logic [18:0] E_ALUWBOV  = {4'b0000, 1'b0, 2'b00, 2'b00, 10'b0000010001};
   localparam logic [18:0] E_ADDIWB   = {4'b0000, 1'b0, 2'b00, 2'b00, 10'b0000000100};
   localparam logic [18:0] E_BRTAKEN  = {4'b0110, 1'b1, 2'b00, 2'b01, 10'b1000000000};
   localparam logic [18:0] E_BRNOT    = {4'b0110, 1'b1, 2'b00, 2'b01, 10'b0000000000};
   localparam logic [18:0] E_JUMP     = {4'b0000, 1'b0, 2'b00, 2'b10, 10'b1000000000};
   localparam logic [18:0] E_ILLEGAL  = {4'b0000, 1'b0, 2'b00, 2'b00, 10'b0000000010};

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam logic [5:0] F_SUB = 6'b100010, F_AND = 6'b100100;

   logic        clk;
   logic        reset_n;
   logic [18:0] act;
   exp_t        sb[$];
   int          n_tests;
   int          n_fail;

   mc_control_if bus ();

   mc_control #(.SIZE(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   assign act = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.pc_write,
                 bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                 bus.mem_to_reg, bus.reg_write, bus.illegal_op, bus.ovf_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [18:0] a, input logic [18:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", name, a, e);
      end
   endtask

   // Monitor: every cycle with a pending expectation is compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.name, act, e.v);
      end
   end

   // One clock cycle of stimulus; caller is positioned just after a rising edge.
   task automatic cycle(input string name, input logic mr, input logic [5:0] opc,
                        input logic [5:0] fn, input logic z, input logic ov,
                        input logic [18:0] e);
      exp_t x;
      bus.mem_ready = mr;
      bus.opcode    = opc;
      bus.funct     = fn;
      bus.zero      = z;
      bus.overflow  = ov;
      x.name = name;
      x.v    = e;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t x;
      n_tests = 0;
      n_fail  = 0;
      reset_n       = 1'b0;
      bus.mem_ready = 1'b0;
      bus.opcode    = 6'd0;
      bus.funct     = 6'd0;
      bus.zero      = 1'b0;
      bus.overflow  = 1'b0;
      @(posedge clk);
      #1;
      cycle("reset_a", 1'b0, RT, 6'd0, 1'b0, 1'b0, E_FSTALL);
      cycle("reset_b", 1'b1, LW, 6'd0, 1'b0, 1'b0, E_FETCH);
      reset_n = 1'b1;

      // LW; opcode changed after DECODE must not turn it into a store
      cycle("lw_fetch",  1'b1, LW, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("lw_decode", 1'b1, LW, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("lw_memadr", 1'b1, SW, 6'd0, 1'b0, 1'b0, E_MEMADR);
      cycle("lw_memrd",  1'b1, SW, 6'd0, 1'b0, 1'b0, E_MEMRD);
      cycle("lw_memwb",  1'b1, SW, 6'd0, 1'b0, 1'b0, E_MEMWB);

      // R-type SUB, no overflow
      cycle("sub_fetch",  1'b1, RT, F_SUB, 1'b0, 1'b0, E_FETCH);
      cycle("sub_decode", 1'b1, RT, F_SUB, 1'b0, 1'b0, E_DECODE);
      cycle("sub_exec",   1'b1, RT, F_SUB, 1'b0, 1'b0, E_EXSUB);
      cycle("sub_aluwb",  1'b1, RT, F_SUB, 1'b0, 1'b0, E_ALUWB);

      // R-type SUB with overflow captured in EXEC, dropped afterwards
      cycle("subov_fetch",  1'b1, RT, F_SUB, 1'b0, 1'b0, E_FETCH);
      cycle("subov_decode", 1'b1, RT, F_SUB, 1'b0, 1'b0, E_DECODE);
      cycle("subov_exec",   1'b1, RT, F_SUB, 1'b0, 1'b1, E_EXSUB);
      cycle("subov_aluwb",  1'b1, RT, F_SUB, 1'b0, 1'b0, E_ALUWBOV);

      // AND ignores overflow
      cycle("and_fetch",  1'b1, RT, F_AND, 1'b0, 1'b1, E_FETCH);
      cycle("and_decode", 1'b1, RT, F_AND, 1'b0, 1'b1, E_DECODE);
      cycle("and_exec",   1'b1, RT, F_AND, 1'b0, 1'b1, E_EXAND);
      cycle("and_aluwb",  1'b1, RT, F_AND, 1'b0, 1'b1, E_ALUWB);

      // ADDI
      cycle("addi_fetch",  1'b1, ADDI, 6'd0, 1'b0, 1'b1, E_FETCH);
      cycle("addi_decode", 1'b1, ADDI, 6'd0, 1'b0, 1'b1, E_DECODE);
      cycle("addi_ex",     1'b1, ADDI, 6'd0, 1'b0, 1'b1, E_MEMADR);
      cycle("addi_wb",     1'b1, ADDI, 6'd0, 1'b0, 1'b1, E_ADDIWB);

      // BEQ taken then not taken
      cycle("beq1_fetch",  1'b1, BEQ, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("beq1_decode", 1'b1, BEQ, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("beq1_branch", 1'b1, BEQ, 6'd0, 1'b1, 1'b0, E_BRTAKEN);
      cycle("beq0_fetch",  1'b1, BEQ, 6'd0, 1'b1, 1'b0, E_FETCH);
      cycle("beq0_decode", 1'b1, BEQ, 6'd0, 1'b1, 1'b0, E_DECODE);
      cycle("beq0_branch", 1'b1, BEQ, 6'd0, 1'b0, 1'b0, E_BRNOT);

      // J
      cycle("j_fetch",  1'b1, JMP, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("j_decode", 1'b1, JMP, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("j_jump",   1'b1, JMP, 6'd0, 1'b0, 1'b0, E_JUMP);

      // Illegal opcode, then R-type with unsupported funct
      cycle("ill1_fetch",  1'b1, 6'b111111, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("ill1_decode", 1'b1, 6'b111111, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("ill1_state",  1'b1, 6'b111111, 6'd0, 1'b0, 1'b0, E_ILLEGAL);
      cycle("ill2_fetch",  1'b1, RT, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("ill2_decode", 1'b1, RT, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("ill2_state",  1'b1, RT, 6'd0, 1'b0, 1'b0, E_ILLEGAL);

      // SW with one fetch stall and three MEMWR stalls
      cycle("sw_fstall",  1'b0, SW, 6'd0, 1'b0, 1'b0, E_FSTALL);
      cycle("sw_fetch",   1'b1, SW, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("sw_decode",  1'b1, SW, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("sw_memadr",  1'b1, LW, 6'd0, 1'b0, 1'b0, E_MEMADR);
      cycle("sw_memwr0",  1'b0, LW, 6'd0, 1'b0, 1'b0, E_MEMWR);
      cycle("sw_memwr1",  1'b0, LW, 6'd0, 1'b0, 1'b0, E_MEMWR);
      cycle("sw_memwr2",  1'b0, LW, 6'd0, 1'b0, 1'b0, E_MEMWR);
      cycle("sw_memwr3",  1'b1, LW, 6'd0, 1'b0, 1'b0, E_MEMWR);

      // LW interrupted by async reset while stalled in MEMRD
      cycle("rst_fetch",  1'b1, LW, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("rst_decode", 1'b1, LW, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("rst_memadr", 1'b1, LW, 6'd0, 1'b0, 1'b0, E_MEMADR);
      bus.mem_ready = 1'b0;
      x.name = "rst_memrd";
      x.v    = E_MEMRD;
      sb.push_back(x);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", act, E_FSTALL);
      @(posedge clk);
      #1;
      cycle("rst_hold", 1'b0, LW, 6'd0, 1'b0, 1'b0, E_FSTALL);
      reset_n = 1'b1;
      cycle("post_fetch",  1'b1, JMP, 6'd0, 1'b0, 1'b0, E_FETCH);
      cycle("post_decode", 1'b1, JMP, 6'd0, 1'b0, 1'b0, E_DECODE);
      cycle("post_jump",   1'b1, JMP, 6'd0, 1'b0, 1'b0, E_JUMP);
      cycle("post_next",   1'b1, JMP, 6'd0, 1'b0, 1'b0, E_FETCH);

      @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the MIPS datapath: the initiator side of the ALU's `ALUOp` interface. A state machine sequences each instruction through fetch, decode, execute, memory and writeback. In every state it drives the 4-bit ALU operation code and all datapath enables, and it consumes the ALU's `zero` and `overflow` flags. It sits between the instruction register, which supplies opcode and funct, and the datapath muxes and register enables.

## Interface
- `SIZE`, default 32: datapath width. It has no effect on control logic and is kept for consistency with the ALU instance.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0]; used only when `opcode` = 000000.
- `zero`  in  1  ALU zero flag.
- `overflow`  in  1  ALU overflow flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_op`  out  4  ALU operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- `alu_src_a`  out  1  ALU A source: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B source: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_write`, `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_dst`, `mem_to_reg`, `reg_write`  out  1 each  datapath enables and selects.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `ovf_err`  out  1  one-cycle pulse when an R-type ADD/SUB overflow suppresses writeback.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL.
- **Transitions:**
  - FETCH→DECODE when `mem_ready`; otherwise stay in FETCH.
  - DECODE branches on opcode:
    - LW (100011) or SW (101011) → MEMADR.
    - R-type (000000) → EXEC.
    - BEQ (000100) → BRANCH.
    - ADDI (001000) → ADDIEX.
    - J (000010) → JUMP.
    - Anything else → ILLEGAL.
  - MEMADR→MEMRD for LW, →MEMWR for SW.
  - MEMRD→MEMWB when `mem_ready`; otherwise stay.
  - MEMWR→FETCH when `mem_ready`; otherwise stay.
  - EXEC→ALUWB, ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP and ILLEGAL all → FETCH.
- **Outputs:** Moore, decoded from the state register only, except where noted.
  - FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD, `pc_src`=00. `ir_write` and `pc_write` equal `mem_ready`.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=ADD (branch target precompute).
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD.
  - MEMRD: `mem_read`=1, `iord`=1.
  - MEMWR: `mem_write`=1, `iord`=1.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR.
  - ALUWB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=!ovf_q.
  - ADDIWB: `reg_dst`=0, `reg_write`=1. ADDI overflow is ignored.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=SUB, `pc_src`=01, `pc_write`=`zero` (Mealy on `zero`).
  - JUMP: `pc_src`=10, `pc_write`=1.
- **Unsupported funct:** an R-type with any other funct is decoded in DECODE and goes to ILLEGAL instead of EXEC.
- **Overflow capture:** `ovf_q` register; EXEC loads `overflow` when funct is ADD or SUB, else loads 0.
- **`ovf_err`:** asserted in ALUWB when `ovf_q`=1.
- **`illegal_op`:** asserted in ILLEGAL.
- **Defaults:** every output not listed for a state is 0. `alu_op` defaults to AND (0000).

## Timing
- **Reset:** `reset_n` low forces state=FETCH and `ovf_q`=0 immediately. All outputs take their FETCH values, gated by `mem_ready`.
- **Reset mid-instruction:** abandons the instruction. No write enable is asserted after reset asserts.
- **Latency with `mem_ready` held 1:**
  - LW: 5 cycles.
  - SW, R-type, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - ILLEGAL: 3 cycles.
- **Memory stalls:** each cycle `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs are held constant while stalled.
- **Input sampling:** `opcode` and `funct` are sampled only in DECODE and EXEC. Changes elsewhere have no effect.

## Structure
- **Package `mips_ctrl_pkg`:** state enumeration, opcode constants, funct constants, and ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB). The ALU shares these constants.
- **Sub-module `alu_decode`:** combinational funct→`alu_op` plus legality flag. Used in both DECODE (legality) and EXEC (op).

## Test plan
- **LW:** reset, `mem_ready`=1, opcode 100011 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_write`=1 and `mem_to_reg`=1 only in cycle 5.
- **R-type SUB:** funct 100010, `overflow`=0 in EXEC → `alu_op`=0110 in EXEC, `reg_write`=1 in ALUWB. Repeat with `overflow`=1 → `reg_write`=0, `ovf_err`=1 for one cycle.
- **BEQ:** opcode 000100, `zero`=1 → `pc_write`=1 and `pc_src`=01 in BRANCH. With `zero`=0 → `pc_write`=0. FETCH follows in both cases.
- **Stall:** SW with `mem_ready` low for 3 cycles in MEMWR → `mem_write` held 1 for 4 cycles; FETCH on the cycle after `mem_ready` rises.
- **Illegal:** opcode 111111, then R-type with funct 000000 → `illegal_op` pulses once each; no `reg_write`, `mem_write` or `pc_write` besides FETCH.
- **Async reset:** `reset_n` low during MEMRD → state is FETCH before the next clock edge, `mem_read`=1 and `iord`=0.
